filter2d_ctrl: RTL and testbench
================================

FILTER2D_CTRL -- requirements
Module: filter2d_ctrl

Parameters
REQ-001 SHALL provide parameter AW, default 17, memory address width (256x256x2 buffer).
REQ-002 SHALL provide parameter WD, default 8, memory data and coefficient width.
REQ-003 SHALL provide parameter TIMEOUT, default 200000, maximum RUN cycles before abort.

Interface
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 go  in  1  job request pulse from host.
REQ-007 busy  out  1  high from the cycle after go is accepted until the cycle done is high.
REQ-008 done  out  1  one-cycle job-complete pulse.
REQ-009 err  out  1  sticky timeout flag; cleared on accepted go.
REQ-010 coef_wr, coef_idx[3:0], coef_data[WD-1:0]  in  host writes into 9-entry coefficient shadow.
REQ-011 h_write, h_idx[3:0], h_data[WD-1:0]  out  coefficient load port to filter engine.
REQ-012 f_start  out  1 / f_finish  in  1  engine start pulse and completion pulse.
REQ-013 f_cs, f_we, f_addr[AW-1:0], f_wdata[WD-1:0]  in  engine memory request.
REQ-014 m_cs, m_we, m_addr[AW-1:0], m_wdata[WD-1:0]  in  host memory request; m_gnt  out  1  host owns memory.
REQ-015 mem_cs, mem_we, mem_addr[AW-1:0], mem_wdata[WD-1:0]  out  to single-port buffer; read data bypasses this block.

Function
REQ-016 States SHALL be IDLE, LOAD, START, RUN, DONE.
REQ-017 IDLE: go=1 -> LOAD next cycle; err cleared; go in any other state ignored.
REQ-018 LOAD: 9 cycles, h_write=1, h_idx=0..8 ascending, h_data=shadow[h_idx]; after idx 8 -> START.
REQ-019 START: f_start=1 exactly one cycle -> RUN; f_start=1 exactly 10 cycles after go sampled.
REQ-020 RUN: f_finish=1 -> DONE; f_finish outside RUN ignored.
REQ-021 RUN: cycle counter from 0; counter reaching TIMEOUT-1 without f_finish -> err=1, DONE.
REQ-022 f_finish and timeout in same cycle: finish wins, err stays 0.
REQ-023 DONE: done=1 one cycle -> IDLE.
REQ-024 Shadow write when coef_wr=1, state IDLE, coef_idx<=8; writes with idx>8 or state!=IDLE dropped.
REQ-025 coef_wr and go same cycle: write applied; new value used by the LOAD that follows.
REQ-026 Ownership: engine in START and RUN, host in all other states; m_gnt=1 iff host owns (combinational from state).
REQ-027 mem_* SHALL combinationally mirror owner's request; non-owner request ignored, never queued.
REQ-028 mem_we SHALL be 0 whenever mem_cs=0.

Reset
REQ-029 reset=1 SHALL force IDLE, clear shadow to 0, RUN counter to 0, err=0 on next edge.
REQ-030 During reset: busy, done, h_write, f_start=0; h_idx=0, h_data=0; m_gnt=1.
REQ-031 Reset mid-LOAD or mid-RUN SHALL abort without done pulse; host owns memory the following cycle.

Verification
REQ-032 Write shadow 1..9, go at cycle N -> h_write cycles N+1..N+9 with h_data 1..9, f_start at N+10, m_gnt=0 from N+10.
REQ-033 f_finish 50 cycles after f_start -> done one cycle later, err=0, m_gnt=1, busy=0 after done.
REQ-034 TIMEOUT=16, no f_finish -> done and err=1 on 16th RUN cycle; next go clears err.
REQ-035 Host m_cs=1, m_we=1, m_addr=0x10000 during RUN with engine f_cs=1, f_addr=0x00005 -> mem_addr=0x00005, host write never reaches memory.
REQ-036 coef_wr idx=4 data=0x7F during RUN, and idx=9 in IDLE -> shadow unchanged; next job loads old value at idx 4.
REQ-037 reset asserted at RUN cycle 20 -> no done, f_start=0, m_gnt=1; go afterwards runs full sequence normally.

Source files
------------

// File: rtl/filter2d_ctrl.sv
// rtl/filter2d_ctrl.sv - 2D filter job sequencer: coefficient load, engine start/run, memory ownership
module filter2d_ctrl #(
  parameter int AW      = 17,
  parameter int WD      = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          coef_wr,
  input  logic [3:0]    coef_idx,
  input  logic [WD-1:0] coef_data,
  output logic          h_write,
  output logic [3:0]    h_idx,
  output logic [WD-1:0] h_data,
  output logic          f_start,
  input  logic          f_finish,
  input  logic          f_cs,
  input  logic          f_we,
  input  logic [AW-1:0] f_addr,
  input  logic [WD-1:0] f_wdata,
  input  logic          m_cs,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [WD-1:0] m_wdata,
  output logic          m_gnt,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    lidx;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [WD-1:0] shadow [9];
  logic          timeout_hit;
  logic          eng_owns;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lidx  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 9; i++) shadow[i] <= '0;
    end else begin
      state <= state_nx;
      lidx  <= (state == LOAD) ? lidx + 4'd1 : 4'd0;
      cnt   <= (state == RUN) ? cnt + CW'(1) : '0;
      if (state == IDLE && go)
        err_q <= 1'b0;
      else if (state == RUN && !f_finish && timeout_hit)
        err_q <= 1'b1;
      // Coefficients are only writable while no job is using them
      if (state == IDLE && coef_wr && coef_idx <= 4'd8)
        shadow[coef_idx] <= coef_data;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    h_write  = 1'b0;
    h_idx    = 4'd0;
    h_data   = '0;
    f_start  = 1'b0;
    eng_owns = 1'b0;
    case (state)
      IDLE:  if (go) state_nx = LOAD;
      LOAD:  begin
        busy    = 1'b1;
        h_write = 1'b1;
        h_idx   = lidx;
        h_data  = shadow[lidx];
        if (lidx == 4'd8) state_nx = START;
      end
      START: begin
        busy     = 1'b1;
        f_start  = 1'b1;
        eng_owns = 1'b1;
        state_nx = RUN;
      end
      RUN:   begin
        busy     = 1'b1;
        eng_owns = 1'b1;
        if (f_finish || timeout_hit) state_nx = DONE;
      end
      DONE:  begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Outputs go quiet and the host regains memory as soon as reset is seen
    if (reset) begin
      busy     = 1'b0;
      done     = 1'b0;
      h_write  = 1'b0;
      h_idx    = 4'd0;
      h_data   = '0;
      f_start  = 1'b0;
      eng_owns = 1'b0;
    end
  end

  assign err       = err_q;
  assign m_gnt     = !eng_owns;
  assign mem_cs    = eng_owns ? f_cs : m_cs;
  assign mem_we    = mem_cs & (eng_owns ? f_we : m_we);
  assign mem_addr  = eng_owns ? f_addr : m_addr;
  assign mem_wdata = eng_owns ? f_wdata : m_wdata;

endmodule

// File: tb/tb_filter2d_ctrl.sv
// tb/tb_filter2d_ctrl.sv - scoreboard bench for filter2d_ctrl
module tb_filter2d_ctrl;
  localparam int AW = 17;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          reset, go, go_to, coef_wr, f_finish, f_cs, f_we, m_cs, m_we;
  logic [3:0]    coef_idx;
  logic [WD-1:0] coef_data, f_wdata, m_wdata;
  logic [AW-1:0] f_addr, m_addr;

  logic          busy, done, err, h_write, f_start, m_gnt, mem_cs, mem_we;
  logic [3:0]    h_idx;
  logic [WD-1:0] h_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          t_busy, t_done, t_err, t_h_write, t_f_start, t_m_gnt, t_mem_cs, t_mem_we;
  logic [3:0]    t_h_idx;
  logic [WD-1:0] t_h_data, t_mem_wdata;
  logic [AW-1:0] t_mem_addr;

  filter2d_ctrl #(.AW(AW), .WD(WD), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .err(err),
    .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data),
    .f_start(f_start), .f_finish(f_finish),
    .f_cs(f_cs), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  filter2d_ctrl #(.AW(AW), .WD(WD), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .go(go_to), .busy(t_busy), .done(t_done), .err(t_err),
    .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
    .h_write(t_h_write), .h_idx(t_h_idx), .h_data(t_h_data),
    .f_start(t_f_start), .f_finish(f_finish),
    .f_cs(f_cs), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(t_m_gnt),
    .mem_cs(t_mem_cs), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    idx;
    logic [WD-1:0] data;
  } hexp_t;

  hexp_t         hq[$];
  logic          eq[$];
  logic [WD-1:0] sh [9];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (h_write) begin
        check("h_q_nonempty", hq.size() != 0, 1);
        if (hq.size() != 0) begin
          hexp_t e;
          e = hq.pop_front();
          check("h_idx", h_idx, e.idx);
          check("h_data", h_data, e.data);
        end
      end
      if (done) begin
        check("done_q_nonempty", eq.size() != 0, 1);
        if (eq.size() != 0) check("done_err", err, eq.pop_front());
      end
    end
  end

  task automatic write_coef(input logic [3:0] idx, input logic [WD-1:0] data, input bit idle);
    coef_wr = 1'b1; coef_idx = idx; coef_data = data;
    if (idle && idx <= 4'd8) sh[idx] = data;
    step();
    coef_wr = 1'b0;
  endtask

  // go accepted at cycle N; checks LOAD at N+1..N+9 and START at N+10
  task automatic start_job(input bit wr, input logic [3:0] idx, input logic [WD-1:0] data);
    if (wr) begin
      coef_wr = 1'b1; coef_idx = idx; coef_data = data;
      if (idx <= 4'd8) sh[idx] = data;
    end
    go = 1'b1;
    for (int k = 0; k < 9; k++) hq.push_back('{idx: 4'(k), data: sh[k]});
    eq.push_back(1'b0);
    step();
    go = 1'b0; coef_wr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("load_hw", h_write, 1);
      check("load_fs", f_start, 0);
      step();
    end
    check("start_fs", f_start, 1);
    check("start_gnt", m_gnt, 0);
    check("start_busy", busy, 1);
  endtask

  initial begin
    reset = 1'b1; go = 0; go_to = 0; coef_wr = 0; coef_idx = 0; coef_data = 0;
    f_finish = 0; f_cs = 0; f_we = 0; f_addr = 0; f_wdata = 0;
    m_cs = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    for (int i = 0; i < 9; i++) sh[i] = '0;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hw", h_write, 0);
    check("rst_fs", f_start, 0);
    check("rst_gnt", m_gnt, 1);
    check("rst_err", err, 0);
    reset = 1'b0;
    step();

    // Host owns memory in IDLE; engine request ignored
    m_cs = 1; m_we = 1; m_addr = 17'h10000; m_wdata = 8'h3C;
    f_cs = 1; f_we = 1; f_addr = 17'h00005; f_wdata = 8'h11;
    #1;
    check("idle_addr", mem_addr, 32'h10000);
    check("idle_we", mem_we, 1);
    check("idle_wdata", mem_wdata, 8'h3C);
    m_cs = 0;
    #1;
    check("idle_we_nocs", mem_we, 0);
    m_we = 0; f_cs = 0; f_we = 0;

    for (int i = 0; i < 9; i++) write_coef(4'(i), 8'(i + 1), 1'b1);
    write_coef(4'd9, 8'h55, 1'b1);

    // Job 1: finish 50 cycles after f_start, with host/engine contention mid-run
    start_job(0, 0, 0);
    step(20);
    m_cs = 1; m_we = 1; m_addr = 17'h10000; m_wdata = 8'hEE;
    f_cs = 1; f_we = 0; f_addr = 17'h00005; f_wdata = 8'h11;
    coef_wr = 1; coef_idx = 4'd4; coef_data = 8'h7F;
    #1;
    check("run_addr", mem_addr, 32'h00005);
    check("run_cs", mem_cs, 1);
    check("run_we", mem_we, 0);
    check("run_wdata", mem_wdata, 8'h11);
    check("run_gnt", m_gnt, 0);
    step();
    coef_wr = 0; m_cs = 0; m_we = 0; f_cs = 0;
    step(29);
    f_finish = 1;
    check("pre_done", done, 0);
    step();
    f_finish = 0;
    check("done1", done, 1);
    step();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_gnt", m_gnt, 1);
    check("post_err", err, 0);

    f_finish = 1;
    step();
    f_finish = 0;
    check("idle_finish_busy", busy, 0);
    check("idle_finish_done", done, 0);

    // Job 2: coef write coincident with go is used; shadow[4] kept old value
    start_job(1, 4'd0, 8'hAA);
    step(10);
    f_finish = 1;
    step();
    f_finish = 0;
    check("done2", done, 1);
    step();

    // Timeout instance: abort at 16th RUN cycle, then finish-wins-over-timeout
    go_to = 1;
    step();
    go_to = 0;
    step(9);
    check("to_fs", t_f_start, 1);
    step(16);
    check("to_pre_done", t_done, 0);
    step();
    check("to_done", t_done, 1);
    check("to_err", t_err, 1);
    step();
    check("to_err_sticky", t_err, 1);
    check("to_busy", t_busy, 0);
    go_to = 1;
    step();
    go_to = 0;
    check("to_err_clr", t_err, 0);
    step(9);
    step(16);
    f_finish = 1;
    step();
    f_finish = 0;
    check("to_fin_done", t_done, 1);
    check("to_fin_err", t_err, 0);
    step();
    check("main_idle", busy, 0);

    // Job 3: reset at RUN cycle 20 aborts without done
    start_job(0, 0, 0);
    step(20);
    reset = 1;
    #1;
    check("rrst_busy", busy, 0);
    check("rrst_fs", f_start, 0);
    check("rrst_gnt", m_gnt, 1);
    step();
    reset = 0;
    check("rrst_q_pending", eq.size(), 1);
    eq.delete();
    for (int i = 0; i < 9; i++) sh[i] = '0;
    check("rrst_gnt2", m_gnt, 1);
    check("rrst_busy2", busy, 0);
    check("rrst_done2", done, 0);
    step(3);
    check("rrst_nodone", done, 0);

    // Job 4: full sequence after reset, cleared coefficients
    start_job(0, 0, 0);
    step(5);
    f_finish = 1;
    step();
    f_finish = 0;
    check("done4", done, 1);
    step(2);

    check("sb_h_drain", hq.size(), 0);
    check("sb_done_drain", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
